// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON decryption datapath.
// Contents: FSM state type, default geometry (N/M/T/Cb), round-function
// rotation amounts and the z0 constant sequence used by key expansion.
package simon_pkg;

    localparam int unsigned N_DEF  = 16;
    localparam int unsigned M_DEF  = 4;
    localparam int unsigned T_DEF  = 32;
    localparam int unsigned CB_DEF = 5;

    // Round function f(v) = (v<<<ROT_A & v<<<ROT_B) ^ v<<<ROT_C
    localparam int unsigned ROT_A = 1;
    localparam int unsigned ROT_B = 8;
    localparam int unsigned ROT_C = 2;

    // z0 sequence; bit for round i is Z_SEQ[Z_LEN-1-(i % Z_LEN)] (leftmost first)
    localparam int unsigned Z_LEN = 62;
    localparam logic [Z_LEN-1:0] Z_SEQ =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXPAND,
        DECRYPT,
        DONE
    } state_t;

endpackage

// File: rtl/simon_decrypt_control_if.sv
// Request/response bundle between a SIMON client and the decrypt controller.
// master: drives newData/newKey/readData/cipher/key, observes doneData/doneKey/plain.
// slave : the controller side.
interface simon_decrypt_control_if
    import simon_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned M = M_DEF
);
    logic                  newData;
    logic                  newKey;
    logic                  readData;
    logic [2*N-1:0]        cipher;
    logic [M-1:0][N-1:0]   key;
    logic                  doneData;
    logic                  doneKey;
    logic [2*N-1:0]        plain;

    modport master (
        output newData, newKey, readData, cipher, key,
        input  doneData, doneKey, plain
    );

    modport slave (
        input  newData, newKey, readData, cipher, key,
        output doneData, doneKey, plain
    );
endinterface

// File: rtl/SIMON_keyexpansion.sv
// SIMON key-schedule step (m = 4): produces k[i+4] from k[i], k[i+1], k[i+3]
// and the round index i.
// Ports: k0/k1/k3 = k[i]/k[i+1]/k[i+3], round = i, next_word = k[i+4].
module SIMON_keyexpansion
    import simon_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned Cb = CB_DEF
)(
    input  logic [N-1:0]  k0,
    input  logic [N-1:0]  k1,
    input  logic [N-1:0]  k3,
    input  logic [Cb-1:0] round,
    output logic [N-1:0]  next_word
);
    localparam int unsigned ZW = $clog2(Z_LEN);

    logic [N-1:0]  t0;
    logic [N-1:0]  t1;
    logic [ZW-1:0] z_idx;
    logic          z_bit;

    // t1 = (I ^ S^-1)(S^-3 k3 ^ k1), S^-1 = rotate right
    assign t0 = {k3[2:0], k3[N-1:3]} ^ k1;
    assign t1 = t0 ^ {t0[0], t0[N-1:1]};

    assign z_idx = ZW'(Z_LEN - 1 - (32'(round) % Z_LEN));
    assign z_bit = Z_SEQ[z_idx];

    // ~k0 ^ 3 is k0 ^ c with c = 2^N - 4
    assign next_word = ~k0 ^ t1 ^ N'(3) ^ N'(z_bit);
endmodule

// File: rtl/simon_inv_round.sv
// One SIMON inverse round, purely combinational.
// Ports: in = {x', y'}, key = round key, out = {y', x' ^ f(y') ^ key}.
module simon_inv_round
    import simon_pkg::*;
#(
    parameter int unsigned N = N_DEF
)(
    input  logic [2*N-1:0] in,
    input  logic [N-1:0]   key,
    output logic [2*N-1:0] out
);
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic [N-1:0] rc;
    logic [N-1:0] f;

    assign x  = in[2*N-1:N];
    assign y  = in[N-1:0];

    assign ra = (y << ROT_A) | (y >> (N - ROT_A));
    assign rb = (y << ROT_B) | (y >> (N - ROT_B));
    assign rc = (y << ROT_C) | (y >> (N - ROT_C));
    assign f  = (ra & rb) ^ rc;

    assign out = {y, x ^ f ^ key};
endmodule

// File: rtl/simon_decrypt_control.sv
// Iterative SIMON decryptor: expands the key schedule forward (skipped when
// the cached table is still valid), then runs one inverse round per clock
// with round keys in reverse order.
// Ports: clk, nR (sync active-low reset), bus (slave side of
// simon_decrypt_control_if: newData/newKey/readData/cipher/key in,
// doneData/doneKey/plain out, all outputs registered).
module simon_decrypt_control
    import simon_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned M  = M_DEF,
    parameter int unsigned T  = T_DEF,
    parameter int unsigned Cb = CB_DEF
)(
    input  logic                   clk,
    input  logic                   nR,
    simon_decrypt_control_if.slave bus
);
    if ((2 ** Cb) < T) begin : g_cb_check
        $error("simon_decrypt_control: Cb too narrow for T rounds");
    end

    localparam logic [Cb-1:0] CNT_LAST = Cb'(T - 1);
    localparam logic [Cb-1:0] CNT_ZERO = '0;

    state_t              state;
    state_t              state_next;
    logic [Cb-1:0]       count;
    logic                expand_req;
    logic [2*N-1:0]      p;
    logic [2*N-1:0]      p_next;
    logic [M-1:0][N-1:0] pkeys;
    logic [N-1:0]        keys [T];
    logic [N-1:0]        next_word;
    logic                done_data;
    logic                done_key;
    logic [2*N-1:0]      plain_q;

    // Next schedule word for round `count` from the sliding key window
    SIMON_keyexpansion #(.N(N), .Cb(Cb)) u_kexp (
        .k0        (pkeys[0]),
        .k1        (pkeys[1]),
        .k3        (pkeys[M-1]),
        .round     (count),
        .next_word (next_word)
    );

    simon_inv_round #(.N(N)) u_inv (
        .in  (p),
        .key (keys[count]),
        .out (p_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!nR) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.newData)         state_next = LOAD;
            LOAD:    state_next = expand_req ? EXPAND : DECRYPT;
            EXPAND:  if (count == CNT_LAST)   state_next = DECRYPT;
            DECRYPT: if (count == CNT_ZERO)   state_next = DONE;
            DONE:    if (bus.readData)        state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, round-key table and registered outputs
    always_ff @(posedge clk) begin
        if (!nR) begin
            count      <= '0;
            expand_req <= 1'b0;
            p          <= '0;
            pkeys      <= '0;
            done_data  <= 1'b0;
            done_key   <= 1'b0;
            plain_q    <= '0;
            for (int i = 0; i < T; i++) begin
                keys[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    // A missing table forces expansion even if newKey is low
                    if (bus.newData) begin
                        expand_req <= bus.newKey | ~done_key;
                    end
                end
                LOAD: begin
                    p         <= bus.cipher;
                    pkeys     <= bus.key;
                    done_data <= 1'b0;
                    if (expand_req) begin
                        count    <= CNT_ZERO;
                        done_key <= 1'b0;
                    end else begin
                        count    <= CNT_LAST;
                    end
                end
                EXPAND: begin
                    keys[count] <= pkeys[0];
                    pkeys       <= {next_word, pkeys[M-1:1]};
                    // count parks at T-1, which is where decryption starts
                    if (count == CNT_LAST) begin
                        done_key <= 1'b1;
                    end else begin
                        count <= count + Cb'(1);
                    end
                end
                DECRYPT: begin
                    p <= p_next;
                    if (count != CNT_ZERO) begin
                        count <= count - Cb'(1);
                    end
                end
                DONE: begin
                    plain_q   <= p;
                    done_data <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.doneData = done_data;
    assign bus.doneKey  = done_key;
    assign bus.plain    = plain_q;
endmodule

// File: tb/tb_simon_decrypt_control.sv
// Bench for simon_decrypt_control: transaction-level reference model
// (key schedule, SIMON encrypt/decrypt, latency by formula) compared every
// negedge, plus directed vector, caching, reset, ignore and round-trip runs.
module tb_simon_decrypt_control;
    localparam int unsigned N = 16;
    localparam int unsigned M = 4;
    localparam int unsigned T = 32;

    typedef logic [M-1:0][N-1:0] key_t;
    typedef logic [T-1:0][N-1:0] rk_t;

    logic clk = 1'b0;
    logic nR;

    always #5 clk = ~clk;

    simon_decrypt_control_if #(.N(N), .M(M)) bus ();

    simon_decrypt_control #(.N(N), .M(M), .T(T), .Cb(5)) dut (
        .clk (clk),
        .nR  (nR),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference cipher ----------------
    function automatic logic [15:0] rotl(input logic [15:0] v, input int r);
        return (v << r) | (v >> (16 - r));
    endfunction

    function automatic logic [15:0] ff(input logic [15:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    function automatic rk_t expand_keys(input key_t k);
        string       zs;
        logic [15:0] w [T+M];
        logic [15:0] t;
        rk_t         rk;
        zs = "11111010001001010110000111001101111101000100101011000011100110";
        for (int i = 0; i < M; i++) w[i] = k[i];
        for (int i = 0; i < T - M; i++) begin
            t = rotl(w[i+3], 13) ^ w[i+1];
            t = t ^ rotl(t, 15);
            w[i+M] = w[i] ^ 16'hFFFC ^ t ^ ((zs[i] == 8'h31) ? 16'h0001 : 16'h0000);
        end
        for (int i = 0; i < T; i++) rk[i] = w[i];
        return rk;
    endfunction

    function automatic logic [31:0] encrypt(input logic [31:0] pt, input rk_t rk);
        logic [15:0] x, y, t;
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < T; i++) begin
            t = x;
            x = y ^ ff(x) ^ rk[i];
            y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [31:0] decrypt(input logic [31:0] ct, input rk_t rk);
        logic [15:0] x, y, t;
        x = ct[31:16];
        y = ct[15:0];
        for (int i = T - 1; i >= 0; i--) begin
            t = y;
            y = x ^ ff(y) ^ rk[i];
            x = t;
        end
        return {x, y};
    endfunction

    // ---------------- transaction model + per-cycle compare ----------------
    // phase 0: accepting, 1: busy (m_k edges since accept), 2: result held
    int          m_phase = 0;
    int          m_k     = 0;
    int          m_lat   = 0;
    bit          m_exp   = 1'b0;
    logic        m_dd    = 1'b0;
    logic        m_dk    = 1'b0;
    logic [31:0] m_plain = '0;
    logic [31:0] m_res   = '0;
    rk_t         m_rk;

    // Inputs only change at negedge+1, so values seen here are those of the last posedge
    always @(negedge clk) begin
        if (!nR) begin
            m_phase = 0;
            m_dd    = 1'b0;
            m_dk    = 1'b0;
            m_plain = '0;
        end else begin
            case (m_phase)
                0: if (bus.newData) begin
                    m_exp   = bus.newKey || !m_dk;
                    m_lat   = m_exp ? 2*T + 2 : T + 2;
                    m_k     = 0;
                    m_phase = 1;
                end
                1: begin
                    m_k++;
                    if (m_k == 1) begin
                        m_dd = 1'b0;
                        if (m_exp) begin
                            m_dk = 1'b0;
                            m_rk = expand_keys(bus.key);
                        end
                        m_res = decrypt(bus.cipher, m_rk);
                    end
                    if (m_exp && m_k == T + 1) m_dk = 1'b1;
                    if (m_k == m_lat) begin
                        m_dd    = 1'b1;
                        m_plain = m_res;
                        m_phase = bus.readData ? 0 : 2;
                    end
                end
                2: if (bus.readData) m_phase = 0;
                default: ;
            endcase
        end
        chk("cyc doneData", 64'(bus.doneData), 64'(m_dd));
        chk("cyc doneKey",  64'(bus.doneKey),  64'(m_dk));
        chk("cyc plain",    64'(bus.plain),    64'(m_plain));
    end

    // ---------------- stimulus helpers ----------------
    task automatic run_block(input logic [31:0] c, input key_t k, input logic nk,
                             input logic [31:0] exp_plain, input int exp_lat,
                             input int pulse_at, input string name);
        int j;
        @(negedge clk); #1;
        bus.newData = 1'b1;
        bus.newKey  = nk;
        bus.cipher  = c;
        bus.key     = k;
        @(negedge clk); #1;           // accept edge (edge 0) has passed
        bus.newData = 1'b0;
        j = 1;
        while (j <= 300) begin
            @(negedge clk);           // observing after edge j
            if (j >= 2 && bus.doneData === 1'b1) break;
            #1 bus.newData = (j == pulse_at);
            j++;
        end
        #1 bus.newData = 1'b0;
        chk({name, " latency"}, 64'(j), 64'(exp_lat));
        chk({name, " plain"},   64'(bus.plain), 64'(exp_plain));
        chk({name, " doneKey"}, 64'(bus.doneKey), 64'd1);
    endtask

    task automatic ack();
        @(negedge clk); #1 bus.readData = 1'b1;
        @(negedge clk); #1 bus.readData = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    localparam logic [31:0] VC = 32'hC69BE9BB;
    localparam logic [31:0] VP = 32'h65656877;

    initial begin
        key_t        vk;
        key_t        rkey;
        logic [31:0] pt;
        logic [31:0] ct;
        bit          reuse;

        nR           = 1'b0;
        bus.newData  = 1'b0;
        bus.newKey   = 1'b0;
        bus.readData = 1'b0;
        bus.cipher   = '0;
        bus.key      = '0;
        vk[0] = 16'h0100; vk[1] = 16'h0908; vk[2] = 16'h1110; vk[3] = 16'h1918;
        rkey = vk;

        repeat (3) @(negedge clk);
        chk("reset doneData", 64'(bus.doneData), 64'd0);
        chk("reset doneKey",  64'(bus.doneKey),  64'd0);
        chk("reset plain",    64'(bus.plain),    64'd0);
        #1 nR = 1'b1;

        // Pin the reference model to the published SIMON32/64 vector
        chk("model encrypt", 64'(encrypt(VP, expand_keys(vk))), 64'(VC));
        chk("model decrypt", 64'(decrypt(VC, expand_keys(vk))), 64'(VP));

        // Full run with expansion; newData pulse during EXPAND is ignored
        run_block(VC, vk, 1'b1, VP, 66, 10, "vec expand");

        // Result held for 20 cycles without readData; newData in DONE ignored
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1 bus.newData = (i == 5);
        end
        chk("hold doneData", 64'(bus.doneData), 64'd1);
        chk("hold plain",    64'(bus.plain),    64'(VP));

        // readData with newData in DONE: back to IDLE only, no restart
        @(negedge clk); #1; bus.readData = 1'b1; bus.newData = 1'b1;
        @(negedge clk); #1; bus.readData = 1'b0; bus.newData = 1'b0;
        repeat (5) @(negedge clk);
        chk("no restart doneData", 64'(bus.doneData), 64'd1);
        chk("no restart plain",    64'(bus.plain),    64'(VP));

        // Cached schedule: no expansion, newData pulse during DECRYPT ignored
        run_block(VC, vk, 1'b0, VP, 34, 20, "vec cached");
        ack();
        run_block(VC, vk, 1'b0, VP, 34, -1, "after ack");
        ack();

        // Reset during DECRYPT at count=10 (edge 55 after accept)
        @(negedge clk); #1;
        bus.newData = 1'b1; bus.newKey = 1'b1; bus.cipher = VC; bus.key = vk;
        @(negedge clk); #1 bus.newData = 1'b0;
        repeat (54) @(negedge clk);
        #1 nR = 1'b0;
        @(negedge clk);
        chk("midreset doneData", 64'(bus.doneData), 64'd0);
        chk("midreset doneKey",  64'(bus.doneKey),  64'd0);
        chk("midreset plain",    64'(bus.plain),    64'd0);
        #1 nR = 1'b1;
        // Table invalid after reset, so expansion happens despite newKey=0
        run_block(VC, vk, 1'b0, VP, 66, -1, "post reset");
        ack();

        // Random round trips, occasionally reusing the cached key
        for (int i = 0; i < 100; i++) begin
            reuse = (i > 0) && ($urandom_range(0, 3) == 0);
            if (!reuse) rkey = {$urandom, $urandom};
            pt = $urandom;
            ct = encrypt(pt, expand_keys(rkey));
            run_block(ct, rkey, !reuse, pt, reuse ? 34 : 66,
                      int'($urandom_range(3, 30)), $sformatf("rt%0d", i));
            ack();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
